// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
//
// Shared types and constants for the baccarat game datapath and its controller.
//
// Contents:
//   n           - width of a card code and of a hand score
//   FACE_MIN    - card codes at or above this value count as zero points
//   NATURAL_MIN - a two-card hand scoring at least this is a natural
//   STAND_MIN   - the player stands on this score or higher
//   state_t     - game controller states, in the order a hand is dealt
// -----------------------------------------------------------------------------
package baccarat_pkg;

   localparam int n = 4;

   localparam int unsigned FACE_MIN    = 10;
   localparam int unsigned NATURAL_MIN = 8;
   localparam int unsigned STAND_MIN   = 6;

   // IDLE waits out reset, DEAL_* each load exactly one card register,
   // CHECK and BANKER make the drawing decisions, RESULT latches the lights
   // and DONE holds the finished hand until the next reset.
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      DEAL_P1 = 4'd1,
      DEAL_D1 = 4'd2,
      DEAL_P2 = 4'd3,
      DEAL_D2 = 4'd4,
      CHECK   = 4'd5,
      DEAL_P3 = 4'd6,
      BANKER  = 4'd7,
      DEAL_D3 = 4'd8,
      RESULT  = 4'd9,
      DONE    = 4'd10
   } state_t;

endpackage : baccarat_pkg

// File: rtl/deal_sequencer_banker_rule.sv
// -----------------------------------------------------------------------------
// banker_rule
//
// Purely combinational banker third-card table. Given the dealer's two-card
// score and the point value of the player's third card, it says whether the
// dealer must draw a third card.
//
// Ports:
//   dscore - dealer two-card score, 0..9
//   p3v    - point value of the player's third card, 0..9 (face cards
//            already folded to zero by the caller)
//   draw   - 1 when the dealer takes a third card
// -----------------------------------------------------------------------------
module banker_rule
   import baccarat_pkg::*;
#(
   parameter int n = baccarat_pkg::n
) (
   input  logic [n-1:0] dscore,
   input  logic [n-1:0] p3v,
   output logic         draw
);

   // Inclusive windows on the player's third card that make the dealer draw
   // at dealer scores 4, 5 and 6. Pulled out as named constants so the table
   // below reads the same way the rule is normally written down.
   localparam logic [n-1:0] drawAll3Except = n'(8);
   localparam logic [n-1:0] lowAt4         = n'(2);
   localparam logic [n-1:0] lowAt5         = n'(4);
   localparam logic [n-1:0] lowAt6         = n'(6);
   localparam logic [n-1:0] highWindow     = n'(7);

   logic inWindow4;
   logic inWindow5;
   logic inWindow6;

   // All three windows share the same upper bound of 7, so only the lower
   // bound differs between rows of the table.
   always_comb begin
      inWindow4 = (p3v >= lowAt4) && (p3v <= highWindow);
      inWindow5 = (p3v >= lowAt5) && (p3v <= highWindow);
      inWindow6 = (p3v >= lowAt6) && (p3v <= highWindow);
   end

   // Dealer scores 0-2 always draw and 7 never does. Scores 8 and 9 are
   // naturals that never reach the banker decision, so they simply stand;
   // codes above 9 are not produced by the datapath and also stand.
   always_comb begin
      draw = 1'b0;
      case (dscore)
         n'(0), n'(1), n'(2): draw = 1'b1;
         n'(3):               draw = (p3v != drawAll3Except);
         n'(4):               draw = inWindow4;
         n'(5):               draw = inWindow5;
         n'(6):               draw = inWindow6;
         default:             draw = 1'b0;
      endcase
   end

endmodule : banker_rule

// File: rtl/deal_sequencer.sv
// -----------------------------------------------------------------------------
// deal_sequencer
//
// Game controller for the baccarat datapath. Advances one state per rising
// edge of slow_clock, pulses the six card-register load strobes in dealing
// order, applies the natural / player third-card / banker third-card rules to
// the hand scores coming back from the datapath, and latches the win lights.
//
// Ports:
//   slow_clock        - single clock, everything changes on its rising edge
//   reset             - synchronous, active-high; returns to IDLE and clears
//                       the lights
//   pscore, dscore    - player / dealer hand scores (0..9), combinational from
//                       the card registers
//   pcard3            - raw code held in the player-3 card register (0..15)
//   load_pcard1..3    - one-cycle load strobes for the player card registers
//   load_dcard1..3    - one-cycle load strobes for the dealer card registers
//   player_win_light  - registered, set when the player wins or ties
//   dealer_win_light  - registered, set when the dealer wins or ties
// -----------------------------------------------------------------------------
module deal_sequencer #(
   parameter int n = baccarat_pkg::n
) (
   input  logic         slow_clock,
   input  logic         reset,
   input  logic [n-1:0] pscore,
   input  logic [n-1:0] dscore,
   input  logic [n-1:0] pcard3,
   output logic         load_pcard1,
   output logic         load_pcard2,
   output logic         load_pcard3,
   output logic         load_dcard1,
   output logic         load_dcard2,
   output logic         load_dcard3,
   output logic         player_win_light,
   output logic         dealer_win_light
);

   import baccarat_pkg::*;

   localparam logic [n-1:0] faceMin    = n'(FACE_MIN);
   localparam logic [n-1:0] naturalMin = n'(NATURAL_MIN);
   localparam logic [n-1:0] standMin   = n'(STAND_MIN);

   state_t       state;
   state_t       nextState;
   logic [n-1:0] p3v;
   logic         bankerDraw;
   logic         isNatural;

   // The card register holds the raw code; tens and face cards are worth
   // nothing, so fold them to zero before consulting the banker table.
   always_comb begin
      p3v = pcard3;
      if (pcard3 >= faceMin) begin
         p3v = '0;
      end
   end

   // Either hand reaching 8 or 9 on two cards ends the deal immediately.
   always_comb begin
      isNatural = (pscore >= naturalMin) || (dscore >= naturalMin);
   end

   banker_rule #(
      .n(n)
   ) u_banker_rule (
      .dscore(dscore),
      .p3v   (p3v),
      .draw  (bankerDraw)
   );

   // State register. Reset wins over every transition, including the hold
   // in DONE, so a new hand can only start by pulsing reset.
   always_ff @(posedge slow_clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. The deal itself is a fixed chain; only CHECK and
   // BANKER branch. Each card register captures on the edge leaving its
   // DEAL state, so the scores used in CHECK already include the second
   // dealer card and the pcard3 seen in BANKER is the freshly dealt one.
   // In CHECK the natural test comes first, then a player on 0-5 draws;
   // a player standing on 6-7 leaves the dealer to draw on 0-5 without
   // the banker table, since there is no player third card to consult.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = DEAL_P1;
         DEAL_P1: nextState = DEAL_D1;
         DEAL_D1: nextState = DEAL_P2;
         DEAL_P2: nextState = DEAL_D2;
         DEAL_D2: nextState = CHECK;
         CHECK: begin
            if (isNatural) begin
               nextState = RESULT;
            end else if (pscore < standMin) begin
               nextState = DEAL_P3;
            end else if (dscore < standMin) begin
               nextState = DEAL_D3;
            end else begin
               nextState = RESULT;
            end
         end
         DEAL_P3: nextState = BANKER;
         BANKER:  nextState = bankerDraw ? DEAL_D3 : RESULT;
         DEAL_D3: nextState = RESULT;
         RESULT:  nextState = DONE;
         DONE:    nextState = DONE;
         default: nextState = IDLE;
      endcase
   end

   // Load strobes are a pure decode of the current state, so each one is
   // high for exactly the one cycle spent in its DEAL state and reset
   // (which forces IDLE) silences them on the very next cycle.
   always_comb begin
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      case (state)
         DEAL_P1: load_pcard1 = 1'b1;
         DEAL_D1: load_dcard1 = 1'b1;
         DEAL_P2: load_pcard2 = 1'b1;
         DEAL_D2: load_dcard2 = 1'b1;
         DEAL_P3: load_pcard3 = 1'b1;
         DEAL_D3: load_dcard3 = 1'b1;
         default: ;
      endcase
   end

   // Win lights are captured only on the edge leaving RESULT, so they stay
   // frozen for the whole of DONE. Using >= on both sides lights both lamps
   // on a tie without a separate equality term.
   always_ff @(posedge slow_clock) begin
      if (reset) begin
         player_win_light <= 1'b0;
         dealer_win_light <= 1'b0;
      end else if (state == RESULT) begin
         player_win_light <= (pscore >= dscore);
         dealer_win_light <= (dscore >= pscore);
      end
   end

endmodule : deal_sequencer
